// File: rtl/matmul_pkg.sv
// Shared types and default geometry for the matrix loader.
// Holds the loader state encoding and the default A/B RAM address widths.
package matmul_pkg;

  localparam int unsigned A_ADDR_W_DEFAULT = 12;
  localparam int unsigned B_ADDR_W_DEFAULT = 6;
  localparam int unsigned CYCLE_COUNT_W    = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_A = 2'd1,
    LOAD_B = 2'd2,
    DONE   = 2'd3
  } loader_state_t;

  function automatic logic is_load(input loader_state_t s);
    return (s == LOAD_A) || (s == LOAD_B);
  endfunction

endpackage

// File: rtl/matrix_loader_cycle_counter.sv
// Saturating cycle counter used to measure load duration.
// Synchronous clear wins over enable; the count sticks at all-ones.
module loader_cycle_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_loader.sv
// Streams bytes into matrix A then matrix B RAM write ports, one write per accepted beat.
// Optional LOADER_CHECKSUM_EN adds a 16-bit byte-sum output of the last completed load.
module matrix_loader
  import matmul_pkg::*;
#(
  parameter int unsigned A_ADDR_W = A_ADDR_W_DEFAULT,
  parameter int unsigned B_ADDR_W = B_ADDR_W_DEFAULT
) (
  input  logic                clock,
  input  logic                reset_l,
  input  logic                start,
  input  logic                in_valid,
  input  logic [7:0]          in_data,
  output logic                in_ready,
  output logic                wr_en_a,
  output logic [A_ADDR_W-1:0] wr_addr_a,
  output logic [7:0]          wr_data_a,
  output logic                wr_en_b,
  output logic [B_ADDR_W-1:0] wr_addr_b,
  output logic [7:0]          wr_data_b,
  output logic                busy,
  output logic                done,
  output logic [15:0]         load_cycles
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [15:0]         checksum
`endif
);

  loader_state_t state, state_next;

  logic [A_ADDR_W-1:0]      a_idx;
  logic [B_ADDR_W-1:0]      b_idx;
  logic                     launch;
  logic                     accept;
  logic                     last_a;
  logic                     last_b;
  logic [CYCLE_COUNT_W-1:0] cycle_count;

  assign launch = (state == IDLE) && start;
  assign accept = in_valid && in_ready;
  assign last_a = (a_idx == '1);
  assign last_b = (b_idx == '1);

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = LOAD_A;
      LOAD_A:  if (accept && last_a) state_next = LOAD_B;
      LOAD_B:  if (accept && last_b) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = is_load(state);
    busy     = (state != IDLE);
    done     = (state == DONE);
  end

  // The A index wraps to 0 on its last beat, but the state has already left LOAD_A.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      a_idx     <= '0;
      b_idx     <= '0;
      wr_en_a   <= 1'b0;
      wr_addr_a <= '0;
      wr_data_a <= '0;
      wr_en_b   <= 1'b0;
      wr_addr_b <= '0;
      wr_data_b <= '0;
    end else begin
      wr_en_a <= accept && (state == LOAD_A);
      wr_en_b <= accept && (state == LOAD_B);
      if (launch) begin
        a_idx <= '0;
        b_idx <= '0;
      end else if (accept && (state == LOAD_A)) begin
        a_idx     <= a_idx + 1'b1;
        wr_addr_a <= a_idx;
        wr_data_a <= in_data;
      end else if (accept && (state == LOAD_B)) begin
        b_idx     <= b_idx + 1'b1;
        wr_addr_b <= b_idx;
        wr_data_b <= in_data;
      end
    end
  end

  loader_cycle_counter #(
    .WIDTH(CYCLE_COUNT_W)
  ) u_cycle_counter (
    .clock  (clock),
    .reset_l(reset_l),
    .clear  (launch),
    .enable (busy),
    .count  (cycle_count)
  );

  // Sampled in DONE, before that cycle's own increment lands, so only load cycles count.
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      load_cycles <= '0;
    end else if (state == DONE) begin
      load_cycles <= cycle_count;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [15:0] sum;

  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      sum      <= '0;
      checksum <= '0;
    end else begin
      if (launch) begin
        sum <= '0;
      end else if (accept) begin
        sum <= sum + {8'd0, in_data};
      end
      if (state == DONE) begin
        checksum <= sum;
      end
    end
  end
`endif

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: a small A=4/B=2 instance and a default-width instance.
// Expected writes are queued when beats are driven and popped when the DUT writes.
module tb_matrix_loader;

  localparam int unsigned AW = 4;
  localparam int unsigned BW = 2;

  logic          clock = 1'b0;
  logic          reset_l = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, wr_en_a, wr_en_b, busy, done;
  logic [AW-1:0] wr_addr_a;
  logic [BW-1:0] wr_addr_b;
  logic [7:0]    wr_data_a, wr_data_b;
  logic [15:0]   load_cycles;

  logic          bg_start = 1'b0;
  logic          bg_valid = 1'b0;
  logic [7:0]    bg_data = 8'h00;
  logic          bg_ready, bg_wea, bg_web, bg_busy, bg_done;
  logic [11:0]   bg_addr_a;
  logic [5:0]    bg_addr_b;
  logic [7:0]    bg_data_a, bg_data_b;
  logic [15:0]   bg_lc;

`ifdef LOADER_CHECKSUM_EN
  logic [15:0]   checksum, bg_cs;
`endif

  matrix_loader #(.A_ADDR_W(AW), .B_ADDR_W(BW)) u_dut (
    .clock(clock), .reset_l(reset_l), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en_a(wr_en_a), .wr_addr_a(wr_addr_a), .wr_data_a(wr_data_a),
    .wr_en_b(wr_en_b), .wr_addr_b(wr_addr_b), .wr_data_b(wr_data_b),
    .busy(busy), .done(done), .load_cycles(load_cycles)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  matrix_loader u_big (
    .clock(clock), .reset_l(reset_l), .start(bg_start),
    .in_valid(bg_valid), .in_data(bg_data), .in_ready(bg_ready),
    .wr_en_a(bg_wea), .wr_addr_a(bg_addr_a), .wr_data_a(bg_data_a),
    .wr_en_b(bg_web), .wr_addr_b(bg_addr_b), .wr_data_b(bg_data_b),
    .busy(bg_busy), .done(bg_done), .load_cycles(bg_lc)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(bg_cs)
`endif
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       mat;
    logic [3:0] addr;
    logic [7:0] data;
  } exp_wr_t;

  exp_wr_t     exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          m_phase = 0;
  int          m_idx = 0;
  int          m_cyc = 0;
  int          done_seen = 0;
  logic [15:0] m_lc = 16'h0;
  logic [15:0] m_sum = 16'h0;
  logic [15:0] m_cs = 16'h0;
  logic [7:0]  ram_a [16];
  logic [7:0]  ram_b [4];

  task automatic model_reset();
    m_phase = 0; m_idx = 0; m_cyc = 0;
    m_lc = 16'h0; m_sum = 16'h0; m_cs = 16'h0;
    exp_q.delete();
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 16; i++) ram_a[i] = 8'hxx;
    for (int i = 0; i < 4; i++) ram_b[i] = 8'hxx;
  endtask

  // One clock of stimulus, reference-model update at the edge, checks at the falling edge.
  task automatic step(input logic s, input logic v, input logic [7:0] d);
    exp_wr_t e;
    logic    ew_a, ew_b;
    start = s; in_valid = v; in_data = d;
    @(posedge clock);
    case (m_phase)
      0: if (s) begin m_phase = 1; m_idx = 0; m_cyc = 0; m_sum = 16'h0; end
      1, 2: begin
        m_cyc++;
        if (v) begin
          exp_q.push_back({(m_phase == 2), 4'(m_idx), d});
          m_sum = m_sum + {8'd0, d};
          if (m_idx == ((m_phase == 1) ? 15 : 3)) begin
            m_phase = m_phase + 1; m_idx = 0;
          end else begin
            m_idx++;
          end
        end
      end
      default: begin m_phase = 0; m_lc = 16'(m_cyc); m_cs = m_sum; end
    endcase
    @(negedge clock);
    start = 1'b0; in_valid = 1'b0;
    ew_a = 1'b0; ew_b = 1'b0; e = '0;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      ew_a = !e.mat; ew_b = e.mat;
    end
    checks++;
    if (wr_en_a !== ew_a || wr_en_b !== ew_b) begin
      errors++; $display("FAIL wr_en: got a=%b b=%b expected a=%b b=%b", wr_en_a, wr_en_b, ew_a, ew_b);
    end
    if (ew_a) begin
      checks++;
      if (wr_addr_a !== e.addr[AW-1:0] || wr_data_a !== e.data) begin
        errors++; $display("FAIL write_a: got %0d/%h expected %0d/%h", wr_addr_a, wr_data_a, e.addr, e.data);
      end
    end
    if (ew_b) begin
      checks++;
      if (wr_addr_b !== e.addr[BW-1:0] || wr_data_b !== e.data) begin
        errors++; $display("FAIL write_b: got %0d/%h expected %0d/%h", wr_addr_b, wr_data_b, e.addr, e.data);
      end
    end
    checks++;
    if (in_ready !== (m_phase == 1 || m_phase == 2) || busy !== (m_phase != 0) || done !== (m_phase == 3)) begin
      errors++; $display("FAIL status: got rdy=%b busy=%b done=%b phase=%0d", in_ready, busy, done, m_phase);
    end
    checks++;
    if (load_cycles !== m_lc) begin
      errors++; $display("FAIL load_cycles_hold: got %0d expected %0d", load_cycles, m_lc);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (checksum !== m_cs) begin
      errors++; $display("FAIL checksum: got %h expected %h", checksum, m_cs);
    end
`endif
    if (wr_en_a === 1'b1) ram_a[wr_addr_a] = wr_data_a;
    if (wr_en_b === 1'b1) ram_b[wr_addr_b] = wr_data_b;
    if (done === 1'b1) done_seen++;
  endtask

  task automatic check_ram(input logic [7:0] base);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ram_a[i] !== base + 8'(i)) begin
        errors++; $display("FAIL ram_a[%0d]: got %h expected %h", i, ram_a[i], base + 8'(i));
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ram_b[i] !== base + 8'(16 + i)) begin
        errors++; $display("FAIL ram_b[%0d]: got %h expected %h", i, ram_b[i], base + 8'(16 + i));
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_l = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b0 || wr_en_a !== 1'b0 || wr_en_b !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got rdy=%b wa=%b wb=%b busy=%b done=%b", in_ready, wr_en_a, wr_en_b, busy, done);
    end
    checks++;
    if (wr_addr_a !== '0 || wr_addr_b !== '0 || wr_data_a !== 8'h00 || wr_data_b !== 8'h00 || load_cycles !== 16'h0) begin
      errors++; $display("FAIL reset_data: got aa=%h ab=%h da=%h db=%h lc=%h", wr_addr_a, wr_addr_b, wr_data_a, wr_data_b, load_cycles);
    end
    model_reset();
    repeat (2) @(negedge clock);
    reset_l = 1'b1;
  endtask

  task automatic test_full_load(input logic [7:0] base, input bit gaps, input int exp_cycles);
    clear_ram();
    done_seen = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) begin
      if (gaps) step(1'b0, 1'b0, 8'hEE);
      step(1'b0, 1'b1, base + 8'(i));
    end
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (load_cycles !== 16'(exp_cycles)) begin
      errors++; $display("FAIL load_cycles: got %0d expected %0d", load_cycles, exp_cycles);
    end
    checks++;
    if (done_seen !== 1) begin
      errors++; $display("FAIL done_pulses: got %0d expected 1", done_seen);
    end
    check_ram(base);
  endtask

  task automatic test_reset_midload();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h30 + 8'(i));
    #2 reset_l = 1'b0;
    #1;
    checks++;
    if (wr_en_a !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || wr_addr_a !== '0) begin
      errors++; $display("FAIL midload_reset: got wa=%b busy=%b rdy=%b addr=%0d", wr_en_a, busy, in_ready, wr_addr_a);
    end
    model_reset();
    repeat (2) begin
      @(negedge clock);
      checks++;
      if (wr_en_a !== 1'b0 || wr_en_b !== 1'b0) begin
        errors++; $display("FAIL write_in_reset: got a=%b b=%b expected 0 0", wr_en_a, wr_en_b);
      end
    end
    reset_l = 1'b1;
    test_full_load(8'hA0, 1'b0, 20);
  endtask

  task automatic test_start_ignored();
    clear_ram();
    done_seen = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'h50 + 8'(i));
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (done_seen !== 1) begin
      errors++; $display("FAIL start_ignored_done: got %0d pulses expected 1", done_seen);
    end
    checks++;
    if (load_cycles !== 16'd20) begin
      errors++; $display("FAIL start_ignored_cycles: got %0d expected 20", load_cycles);
    end
  endtask

  task automatic test_back_to_back();
    clear_ram();
    done_seen = 0;
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h60 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    clear_ram();
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'h80 + 8'(i));
    step(1'b0, 1'b0, 8'h00);
    checks++;
    if (done_seen !== 2) begin
      errors++; $display("FAIL b2b_done: got %0d pulses expected 2", done_seen);
    end
    check_ram(8'h80);
  endtask

  task automatic test_idle_valid();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'hC0 + 8'(i));
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL idle_queue: got %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic test_default_widths();
    logic [15:0] sum;
    logic        exp_a;
    sum = 16'h0;
    bg_start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bg_start = 1'b0;
    checks++;
    if (bg_busy !== 1'b1 || bg_ready !== 1'b1) begin
      errors++; $display("FAIL big_start: got busy=%b rdy=%b expected 1 1", bg_busy, bg_ready);
    end
    for (int i = 0; i < 4160; i++) begin
      bg_valid = 1'b1; bg_data = 8'hFF;
      @(posedge clock);
      @(negedge clock);
      bg_valid = 1'b0;
      sum = sum + 16'h00FF;
      exp_a = (i < 4096);
      checks++;
      if (bg_wea !== exp_a || bg_web !== !exp_a) begin
        errors++; $display("FAIL big_wr_en beat %0d: got a=%b b=%b", i, bg_wea, bg_web);
      end else if (exp_a && (bg_addr_a !== 12'(i) || bg_data_a !== 8'hFF)) begin
        errors++; $display("FAIL big_write_a beat %0d: got %0d/%h", i, bg_addr_a, bg_data_a);
      end else if (!exp_a && (bg_addr_b !== 6'(i - 4096) || bg_data_b !== 8'hFF)) begin
        errors++; $display("FAIL big_write_b beat %0d: got %0d/%h", i, bg_addr_b, bg_data_b);
      end
    end
    checks++;
    if (bg_done !== 1'b1) begin
      errors++; $display("FAIL big_done: got %b expected 1", bg_done);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (bg_lc !== 16'd4160 || bg_busy !== 1'b0 || bg_done !== 1'b0) begin
      errors++; $display("FAIL big_load_cycles: got %0d busy=%b done=%b expected 4160 0 0", bg_lc, bg_busy, bg_done);
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (bg_cs !== sum) begin
      errors++; $display("FAIL big_checksum: got %h expected %h", bg_cs, sum);
    end
`else
    checks++;
    if (sum !== 16'h2FC0) begin
      errors++; $display("FAIL big_sum_model: got %h expected 2fc0", sum);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_full_load(8'h01, 1'b0, 20);
    test_full_load(8'h01, 1'b1, 40);
    test_reset_midload();
    test_start_ignored();
    test_back_to_back();
    test_idle_valid();
    test_default_widths();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
